// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use and HI/LO-busy stalls plus the mult/div busy sequencer.
// Optional macro HAZARD_STAT_EN adds free-running stall statistics counters.
module hazard_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rsD,
   input  logic [4:0] rtD,
   input  logic       useRsD,
   input  logic       useRtD,
   input  logic       mdD,
   input  logic       ldE,
   input  logic [4:0] rwaE,
   input  logic       mdStartE,
   input  logic       mdDivE,
   output logic       stall,
   output logic       flushE,
   output logic       mdBusy,
   output logic [3:0] mdCnt
`ifdef HAZARD_STAT_EN
   ,
   output logic [31:0] stallCnt,
   output logic [31:0] mdStallCnt
`endif
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] MULT_RELOAD = 4'(MULT_LAT - 1);
   localparam logic [3:0] DIV_RELOAD  = 4'(DIV_LAT - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [3:0] reloadCnt;
   logic       ldHz;
   logic       mdHz;

   assign reloadCnt = mdDivE ? DIV_RELOAD : MULT_RELOAD;

   // A new start always reloads, even mid-BUSY; a single-cycle op never enters BUSY.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else if (mdStartE) begin
         cnt   <= reloadCnt;
         state <= (reloadCnt == 4'd0) ? IDLE : BUSY;
      end else if (state == BUSY) begin
         if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
         end else begin
            cnt   <= 4'd0;
            state <= IDLE;
         end
      end
   end

   // Gating with reset keeps every output quiet while reset is held, whatever the inputs do.
   assign mdBusy = reset & ((state == BUSY) | mdStartE);
   assign ldHz   = reset & ldE & (rwaE != 5'd0) &
                   ((useRsD & (rsD == rwaE)) | (useRtD & (rtD == rwaE)));
   assign mdHz   = mdD & mdBusy;
   assign stall  = ldHz | mdHz;
   assign flushE = stall;
   assign mdCnt  = cnt;

`ifdef HAZARD_STAT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stallCnt   <= 32'd0;
         mdStallCnt <= 32'd0;
      end else begin
         if (stall) stallCnt <= stallCnt + 32'd1;
         if (mdHz)  mdStallCnt <= mdStallCnt + 32'd1;
      end
   end
`endif

endmodule
